// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and the Q8.8 shift/saturate helper for the
// fully-connected classifier stage.
package fc_pkg;

  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACCW  = 40;
  localparam int N_IN  = 196;
  localparam int N_OUT = 10;
  localparam int AW    = 12;
  localparam int IW    = $clog2(N_IN);
  localparam int OW    = $clog2(N_OUT);

  localparam logic signed [DW-1:0] Q88_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] Q88_MAX = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Drop the fraction, then clamp: in range iff all bits above the Q8.8 sign agree.
  function automatic logic signed [DW-1:0] sat_q88(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] sh;
    sh = acc >>> FRAC;
    if (sh[ACCW-1:DW-1] == '0 || sh[ACCW-1:DW-1] == '1)
      return sh[DW-1:0];
    else if (sh[ACCW-1])
      return Q88_MIN;
    else
      return Q88_MAX;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Single multiply-accumulate lane: unsigned activation x signed weight, with
// per-neuron clear-on-last, bias add and Q8.8 saturation of the finished sum.
module fc_mac
  import fc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 last,
  input  logic [DW-1:0]        act,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] result,
  output logic                 result_valid
);

  logic signed [2*DW:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [ACCW-1:0] acc;

  assign prod     = $signed({1'b0, act}) * w;
  assign prod_ext = {{(ACCW-2*DW-1){prod[2*DW]}}, prod};
  assign bias_ext = {{(ACCW-DW){bias[DW-1]}}, bias} <<< FRAC;
  assign result   = sat_q88(acc + bias_ext);

  // result_valid marks the cycle where acc holds a finished neuron; the next
  // neuron's first product overwrites it in that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      result_valid <= 1'b0;
    end else if (clr) begin
      acc          <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= en && last;
      if (en)
        acc <= (result_valid ? '0 : acc) + prod_ext;
      else if (result_valid)
        acc <= '0;
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected classifier: snapshots the pooled map, streams weights from an
// external ROM through one MAC, and keeps saturated scores plus the argmax.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last results
// RUN   | issuing weight addresses 0..N_OUT*N_IN-1
// FLUSH | address stream finished, draining the MAC pipeline
// DONE  | one-cycle done pulse, then back to IDLE
module fc_layer
  import fc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DW*N_IN-1:0]   pool_in,
  input  logic [DW*N_OUT-1:0]  bias_in,
  output logic [AW-1:0]        w_addr,
  input  logic [DW-1:0]        w_data,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [DW*N_OUT-1:0]  fc_out,
  output logic [OW-1:0]        class_idx
);

  state_t state_q, state_d;

  logic [DW*N_IN-1:0]   snap;
  logic [IW-1:0]        i_cnt, i_d1;
  logic [OW-1:0]        o_cnt, res_o;
  logic                 v_d1, last_d1;
  logic [DW-1:0]        act;
  logic signed [DW-1:0] bias_sel, result, max_val;
  logic                 result_valid, last_addr, accept, final_res;

  assign last_addr = (o_cnt == OW'(N_OUT-1)) && (i_cnt == IW'(N_IN-1));
  assign accept    = (state_q == IDLE) && start;
  assign final_res = result_valid && (res_o == OW'(N_OUT-1));
  assign act       = snap[i_d1*DW +: DW];
  assign bias_sel  = bias_in[res_o*DW +: DW];

  fc_mac u_mac (
    .clk          (clk),
    .rst          (rst),
    .clr          (accept),
    .en           (v_d1),
    .last         (last_d1),
    .act          (act),
    .w            (w_data),
    .bias         (bias_sel),
    .result       (result),
    .result_valid (result_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_addr) state_d = FLUSH;
      FLUSH:   if (final_res) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      w_addr    <= '0;
      i_cnt     <= '0;
      o_cnt     <= '0;
      i_d1      <= '0;
      v_d1      <= 1'b0;
      last_d1   <= 1'b0;
      snap      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      fc_out    <= '0;
      class_idx <= '0;
      res_o     <= '0;
      max_val   <= Q88_MIN;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      // ROM data lags the address by one cycle, so the MAC controls do too.
      v_d1    <= (state_q == RUN);
      i_d1    <= i_cnt;
      last_d1 <= (i_cnt == IW'(N_IN-1));

      if (accept) begin
        snap      <= pool_in;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        w_addr    <= '0;
        i_cnt     <= '0;
        o_cnt     <= '0;
        res_o     <= '0;
        max_val   <= Q88_MIN;
        class_idx <= '0;
      end

      if (state_q == RUN && !last_addr) begin
        w_addr <= w_addr + 1'b1;
        if (i_cnt == IW'(N_IN-1)) begin
          i_cnt <= '0;
          o_cnt <= o_cnt + 1'b1;
        end else begin
          i_cnt <= i_cnt + 1'b1;
        end
      end

      // Strictly-greater compare keeps the lowest index on ties.
      if (result_valid) begin
        fc_out[res_o*DW +: DW] <= result;
        res_o <= res_o + 1'b1;
        if (result > max_val) begin
          max_val   <= result;
          class_idx <= res_o;
        end
      end

      if (final_res) begin
        done      <= 1'b1;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: expected scores come from a plain-arithmetic
// dot-product model and are checked by a monitor on each done pulse.
module tb_fc_layer;
  import fc_pkg::*;

  localparam int LAT = N_OUT*N_IN + 2;

  logic                clk, rst, start;
  logic [DW*N_IN-1:0]  pool_in;
  logic [DW*N_OUT-1:0] bias_in;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_data;
  logic                busy, done, out_valid;
  logic [DW*N_OUT-1:0] fc_out;
  logic [OW-1:0]       class_idx;

  fc_layer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pool_in   (pool_in),
    .bias_in   (bias_in),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .fc_out    (fc_out),
    .class_idx (class_idx)
  );

  typedef struct {
    logic [DW*N_OUT-1:0] fc;
    logic [OW-1:0]       idx;
    int                  done_cyc;
  } exp_t;

  logic [DW-1:0] pool [N_IN];
  logic [DW-1:0] bias [N_OUT];
  logic [DW-1:0] rom  [N_IN*N_OUT];
  exp_t          sb [$];
  int            checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_dones = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) w_data <= rom[w_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic exp_t model();
    exp_t   e;
    longint s, best;
    int     bi;
    e.fc = '0;
    best = 0;
    bi   = 0;
    for (int o = 0; o < N_OUT; o++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++)
        s += longint'(pool[i]) * longint'($signed(rom[o*N_IN+i]));
      s = (s + longint'($signed(bias[o])) * 256) >>> 8;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      e.fc[o*DW +: DW] = s[15:0];
      if (o == 0 || s > best) begin
        best = s;
        bi   = o;
      end
    end
    e.idx = bi[OW-1:0];
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic pack();
    for (int k = 0; k < N_IN; k++) pool_in[k*DW +: DW] = pool[k];
    for (int o = 0; o < N_OUT; o++) bias_in[o*DW +: DW] = bias[o];
  endtask

  task automatic fill(input logic [DW-1:0] pv, input logic [DW-1:0] wv);
    for (int k = 0; k < N_IN; k++) pool[k] = pv;
    for (int k = 0; k < N_IN*N_OUT; k++) rom[k] = wv;
    for (int o = 0; o < N_OUT; o++) bias[o] = '0;
  endtask

  task automatic issue();
    exp_t e;
    @(negedge clk);
    pack();
    start = 1'b1;
    e = model();
    e.done_cyc = cyc + 1 + LAT;
    sb.push_back(e);
    exp_dones++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < LAT + 200 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({name, "_out_valid_hold"}, 32'(out_valid), 32'd1);
    check({name, "_done_pulse_len"}, 32'(done), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.done_cyc));
        check("busy_at_done", 32'(busy), 32'd0);
        check("out_valid_at_done", 32'(out_valid), 32'd1);
        check("class_idx", 32'(class_idx), 32'(e.idx));
        for (int o = 0; o < N_OUT; o++)
          check($sformatf("fc_out[%0d]", o), 32'(fc_out[o*DW +: DW]), 32'(e.fc[o*DW +: DW]));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish by cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pool_in = '0;
    bias_in = '0;
    fill('0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fc_out_nz", 32'(|fc_out), 32'd0);
    check("rst_class_idx", 32'(class_idx), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);

    fill(16'h0100, 16'h0001);
    issue();
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done("unit_w");

    fill(16'h0100, 16'h0100);
    issue(); wait_done("sat_hi");
    fill(16'h0100, 16'hFF00);
    issue(); wait_done("sat_lo");

    fill(16'h0100, 16'h0000);
    for (int o = 0; o < N_OUT; o++) bias[o] = 16'(o * 16);
    issue(); wait_done("bias_only");

    fill(16'h0000, 16'h0000);
    pool[5] = 16'h0200;
    rom[3*N_IN+5] = 16'h0180;
    issue(); wait_done("sparse");

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N_IN; k++)
        pool[k] = (r == 0) ? 16'($urandom_range(0, 16'hFFFF)) : 16'($urandom_range(0, 16'h03FF));
      for (int k = 0; k < N_IN*N_OUT; k++)
        rom[k] = (r == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h01FF) - 16'h0100);
      for (int o = 0; o < N_OUT; o++) bias[o] = 16'($urandom);
      issue(); wait_done($sformatf("rand%0d", r));
    end

    // Re-start mid-run with a different map must not disturb the snapshot.
    issue();
    repeat (100) @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    for (int k = 0; k < N_IN; k++) pool[k] = 16'($urandom);
    pack();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_ignored");
    repeat (20) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(exp_dones));

    issue();
    repeat (500) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_fc_out_nz", 32'(|fc_out), 32'd0);
    check("abort_w_addr", 32'(w_addr), 32'd0);
    sb.delete();
    exp_dones--;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < N_IN; k++) pool[k] = 16'($urandom_range(0, 16'h0FFF));
    for (int k = 0; k < N_IN*N_OUT; k++) rom[k] = 16'($urandom_range(0, 16'h00FF) - 16'h0080);
    issue(); wait_done("after_abort");
    repeat (10) @(negedge clk);
    check("final_done_count", 32'(done_cnt), 32'(exp_dones));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
